// File: rtl/vx_tex_wrap_pipe.sv
// Texture coordinate wrap pipeline: applies per-dimension wrap modes to fixed-point
// coordinates (stage 0), then derives integer texel indices from the wrapped fraction (stage 1).
module vx_tex_wrap_pipe #(
    parameter int CORE_ID   = 0,
    parameter int NUM_LANES = 4,
    parameter int NUM_DIMS  = 2,
    parameter int FXD_BITS  = 24,
    parameter int FXD_FRAC  = 16,
    parameter int MAX_LOG   = 12,
    parameter int TAG_W     = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    valid_in,
    output logic                                    ready_in,
    input  logic [NUM_DIMS*2-1:0]                   wrap_in,
    input  logic [NUM_DIMS*$clog2(MAX_LOG+1)-1:0]   log_size_in,
    input  logic [NUM_LANES*NUM_DIMS*FXD_BITS-1:0]  coord_in,
    input  logic [TAG_W-1:0]                        tag_in,
    output logic                                    valid_out,
    input  logic                                    ready_out,
    output logic [NUM_LANES*NUM_DIMS*FXD_FRAC-1:0]  frac_out,
    output logic [NUM_LANES*NUM_DIMS*MAX_LOG-1:0]   texel_out,
    output logic [NUM_LANES*NUM_DIMS-1:0]           border_out,
    output logic [TAG_W-1:0]                        tag_out
);

    localparam int LOG_W = $clog2(MAX_LOG + 1);
    localparam int NC    = NUM_LANES * NUM_DIMS;

    logic [31:0] unused_core_id;
    assign unused_core_id = 32'(CORE_ID);

    // Returns {border, frac} for one coordinate.
    function automatic logic [FXD_FRAC:0] wrap_coord(input logic [1:0] mode,
                                                     input logic [FXD_BITS-1:0] c);
        logic                neg;
        logic                in_rng;
        logic [FXD_FRAC-1:0] low;
        logic [FXD_FRAC-1:0] f;
        logic                b;
        neg    = c[FXD_BITS-1];
        in_rng = (c[FXD_BITS-1:FXD_FRAC] == '0);
        low    = c[FXD_FRAC-1:0];
        f      = low;
        b      = 1'b0;
        case (mode)
            2'd0: begin
                if (neg) f = '0;
                else if (!in_rng) f = '1;
            end
            2'd1: f = low;
            2'd2: f = low ^ {FXD_FRAC{c[FXD_FRAC]}};
            default: begin
                if (!in_rng) begin
                    f = '0;
                    b = 1'b1;
                end
            end
        endcase
        return {b, f};
    endfunction

    // A log size of zero shifts the whole fraction out, yielding texel 0.
    function automatic logic [MAX_LOG-1:0] to_texel(input logic [FXD_FRAC-1:0] f,
                                                    input logic [LOG_W-1:0] lg);
        logic [LOG_W-1:0]    l;
        logic [FXD_FRAC-1:0] t;
        l = (lg > LOG_W'(MAX_LOG)) ? LOG_W'(MAX_LOG) : lg;
        t = f >> (FXD_FRAC - int'(l));
        return t[MAX_LOG-1:0];
    endfunction

    logic                s0_valid_q;
    logic                s1_valid_q;
    logic                s1_ready;
    logic                s0_load;
    logic                s1_load;

    logic [FXD_FRAC:0]   s0_wrap_d  [NC];
    logic [FXD_FRAC-1:0] s0_frac_q  [NC];
    logic                s0_border_q[NC];
    logic [LOG_W-1:0]    s0_log_q   [NUM_DIMS];
    logic [TAG_W-1:0]    s0_tag_q;

    logic [MAX_LOG-1:0]  s1_texel_d [NC];
    logic [FXD_FRAC-1:0] s1_frac_q  [NC];
    logic [MAX_LOG-1:0]  s1_texel_q [NC];
    logic                s1_border_q[NC];
    logic [TAG_W-1:0]    s1_tag_q;

    // Stage 0 empties whenever stage 1 can take its entry, so an S1 bubble is absorbed.
    assign s1_ready = ~s1_valid_q | ready_out;
    assign ready_in = ~s0_valid_q | s1_ready;
    assign s0_load  = valid_in & ready_in;
    assign s1_load  = s0_valid_q & s1_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0_valid_q <= 1'b0;
            s1_valid_q <= 1'b0;
        end else begin
            if (ready_in) s0_valid_q <= valid_in;
            if (s1_ready) s1_valid_q <= s0_valid_q;
        end
    end

    for (genvar i = 0; i < NC; i++) begin : g_coord
        localparam int Dim = i % NUM_DIMS;
        assign s0_wrap_d[i]  = wrap_coord(wrap_in[Dim*2 +: 2], coord_in[i*FXD_BITS +: FXD_BITS]);
        assign s1_texel_d[i] = to_texel(s0_frac_q[i], s0_log_q[Dim]);

        assign frac_out[i*FXD_FRAC +: FXD_FRAC] = s1_frac_q[i];
        assign texel_out[i*MAX_LOG +: MAX_LOG]  = s1_texel_q[i];
        assign border_out[i]                    = s1_border_q[i];
    end

    // Data registers carry no reset; they are qualified by the stage valids.
    always_ff @(posedge clk) begin
        if (s0_load) begin
            for (int i = 0; i < NC; i++) begin
                s0_frac_q[i]   <= s0_wrap_d[i][FXD_FRAC-1:0];
                s0_border_q[i] <= s0_wrap_d[i][FXD_FRAC];
            end
            for (int d = 0; d < NUM_DIMS; d++) begin
                s0_log_q[d] <= log_size_in[d*LOG_W +: LOG_W];
            end
            s0_tag_q <= tag_in;
        end
        if (s1_load) begin
            for (int i = 0; i < NC; i++) begin
                s1_frac_q[i]   <= s0_frac_q[i];
                s1_texel_q[i]  <= s1_texel_d[i];
                s1_border_q[i] <= s0_border_q[i];
            end
            s1_tag_q <= s0_tag_q;
        end
    end

    assign valid_out = s1_valid_q;
    assign tag_out   = s1_tag_q;

endmodule

// File: tb/tb_vx_tex_wrap_pipe.sv
// Self-checking bench for vx_tex_wrap_pipe with a reference-model scoreboard.
module tb_vx_tex_wrap_pipe;

    logic         clk;
    logic         reset;
    logic         valid_in;
    logic         ready_in;
    logic [3:0]   wrap_in;
    logic [7:0]   log_size_in;
    logic [191:0] coord_in;
    logic [7:0]   tag_in;
    logic         valid_out;
    logic         ready_out;
    logic [127:0] frac_out;
    logic [95:0]  texel_out;
    logic [7:0]   border_out;
    logic [7:0]   tag_out;

    vx_tex_wrap_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .wrap_in     (wrap_in),
        .log_size_in (log_size_in),
        .coord_in    (coord_in),
        .tag_in      (tag_in),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .frac_out    (frac_out),
        .texel_out   (texel_out),
        .border_out  (border_out),
        .tag_out     (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] frac;
        logic [95:0]  texel;
        logic [7:0]   border;
        logic [7:0]   tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   toggle_ready = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] wr, input logic [7:0] lgs,
                                   input logic [191:0] co, input logic [7:0] tg);
        exp_t e;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            int c, f, b, lg, t, d, mode;
            d    = i % 2;
            c    = int'($signed(co[i*24 +: 24]));
            mode = int'(wr[d*2 +: 2]);
            lg   = int'(lgs[d*4 +: 4]);
            b    = 0;
            case (mode)
                0: f = (c < 0) ? 0 : ((c >= 65536) ? 65535 : c);
                1: f = c & 65535;
                2: f = (((c >>> 16) & 1) != 0) ? (~c & 65535) : (c & 65535);
                default: begin
                    if (c >= 0 && c < 65536) f = c;
                    else begin
                        f = 0;
                        b = 1;
                    end
                end
            endcase
            if (lg > 12) lg = 12;
            t = (lg == 0) ? 0 : ((f >> (16 - lg)) & 'hFFF);
            e.frac[i*16 +: 16] = f[15:0];
            e.texel[i*12 +: 12] = t[11:0];
            e.border[i] = b[0];
        end
        e.tag = tg;
        return e;
    endfunction

    // Monitor: scoreboard push on acceptance, pop on delivery, and hold checks during stalls.
    bit           stalled = 0;
    logic [127:0] held_frac;
    logic [95:0]  held_texel;
    logic [7:0]   held_border;
    logic [7:0]   held_tag;

    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            stalled = 0;
        end else begin
            if (stalled) begin
                check("stall_valid", {127'b0, valid_out}, 128'd1);
                check("stall_frac", frac_out, held_frac);
                check("stall_texel", {32'b0, texel_out}, {32'b0, held_texel});
                check("stall_border", {120'b0, border_out}, {120'b0, held_border});
                check("stall_tag", {120'b0, tag_out}, {120'b0, held_tag});
            end
            stalled     = valid_out && !ready_out;
            held_frac   = frac_out;
            held_texel  = texel_out;
            held_border = border_out;
            held_tag    = tag_out;
            if (valid_out && ready_out) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", {127'b0, valid_out}, 128'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_frac", frac_out, e.frac);
                    check("sb_texel", {32'b0, texel_out}, {32'b0, e.texel});
                    check("sb_border", {120'b0, border_out}, {120'b0, e.border});
                    check("sb_tag", {120'b0, tag_out}, {120'b0, e.tag});
                end
            end
            if (valid_in && ready_in) sb.push_back(model(wrap_in, log_size_in, coord_in, tag_in));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (toggle_ready) ready_out = ~ready_out;
        #1;
    endtask

    // Holds valid_in until accepted; returns just after the accepting edge.
    task automatic send();
        int n;
        n = 0;
        valid_in = 1'b1;
        #1;
        while (!ready_in && n < 50) begin
            step();
            n++;
        end
        if (!ready_in) check("accept_timeout", {127'b0, ready_in}, 128'd1);
        step();
    endtask

    task automatic rand_inputs();
        wrap_in     = 4'($urandom);
        log_size_in = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
        for (int i = 0; i < 8; i++) begin
            coord_in[i*24 +: 24] = 24'($urandom_range(0, 'h40000)) - 24'h20000;
        end
        tag_in = 8'($urandom);
    endtask

    task automatic drain();
        valid_in  = 1'b0;
        ready_out = 1'b1;
        repeat (6) step();
    endtask

    task automatic directed(input string name, input logic [1:0] m, input int c,
                            input logic [3:0] lg, input logic [15:0] ef,
                            input logic [11:0] et, input logic eb);
        wrap_in     = {m, m};
        log_size_in = {lg, lg};
        coord_in    = {8{c[23:0]}};
        tag_in      = tag_in + 8'd1;
        ready_out   = 1'b1;
        send();
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_latency"}, {127'b0, valid_out}, 128'd1);
        check({name, "_frac0"}, {112'b0, frac_out[15:0]}, {112'b0, ef});
        check({name, "_frac7"}, {112'b0, frac_out[127:112]}, {112'b0, ef});
        check({name, "_texel0"}, {116'b0, texel_out[11:0]}, {116'b0, et});
        check({name, "_texel7"}, {116'b0, texel_out[95:84]}, {116'b0, et});
        check({name, "_border0"}, {127'b0, border_out[0]}, {127'b0, eb});
        check({name, "_border7"}, {127'b0, border_out[7]}, {127'b0, eb});
    endtask

    initial begin
        int count;
        reset       = 1'b0;
        valid_in    = 1'b0;
        ready_out   = 1'b1;
        wrap_in     = '0;
        log_size_in = '0;
        coord_in    = '0;
        tag_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid_out", {127'b0, valid_out}, 128'd0);
        check("reset_ready_in", {127'b0, ready_in}, 128'd1);
        reset = 1'b1;
        step();

        directed("clamp_neg", 2'd0, -'h100, 4'd4, 16'h0000, 12'h000, 1'b0);
        directed("clamp_hi", 2'd0, 'h18000, 4'd4, 16'hFFFF, 12'h00F, 1'b0);
        directed("clamp_mid", 2'd0, 'h4000, 4'd4, 16'h4000, 12'h004, 1'b0);
        directed("repeat", 2'd1, 'h18000, 4'd4, 16'h8000, 12'h008, 1'b0);
        directed("repeat_neg_log0", 2'd1, -'h100, 4'd0, 16'hFF00, 12'h000, 1'b0);
        directed("repeat_logclamp", 2'd1, 'h12345, 4'd15, 16'h2345, 12'h234, 1'b0);
        directed("mirror", 2'd2, 'h18000, 4'd4, 16'h7FFF, 12'h007, 1'b0);
        directed("mirror_neg", 2'd2, -'h100, 4'd8, 16'h00FF, 12'h000, 1'b0);
        directed("border_out", 2'd3, 'h10000, 4'd4, 16'h0000, 12'h000, 1'b1);
        directed("border_in", 2'd3, 'hFFFF, 4'd12, 16'hFFFF, 12'hFFF, 1'b0);
        drain();
        check("drain_directed", 128'(sb.size()), 128'd0);

        // Back-to-back with ready_out toggling every cycle.
        toggle_ready = 1;
        ready_out    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_inputs();
            tag_in = 8'(i);
            send();
        end
        toggle_ready = 0;
        drain();
        repeat (4) step();
        check("drain_b2b", 128'(sb.size()), 128'd0);

        // Output stalled: only two requests fit before ready_in drops.
        ready_out = 1'b0;
        valid_in  = 1'b1;
        count     = 0;
        rand_inputs();
        for (int i = 0; i < 5; i++) begin
            #1;
            if (ready_in) count++;
            @(posedge clk);
            #1;
            rand_inputs();
        end
        #1;
        check("stall_accepts", 128'(count), 128'd2);
        check("stall_ready_in", {127'b0, ready_in}, 128'd0);
        drain();
        check("drain_stall", 128'(sb.size()), 128'd0);

        // Random valid/ready traffic.
        for (int i = 0; i < 80; i++) begin
            rand_inputs();
            valid_in  = 1'($urandom_range(0, 1));
            ready_out = 1'($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        check("drain_random", 128'(sb.size()), 128'd0);

        // Reset with two requests in flight.
        ready_out = 1'b0;
        rand_inputs();
        send();
        rand_inputs();
        send();
        valid_in = 1'b0;
        check("inflight_valid", {127'b0, valid_out}, 128'd1);
        reset = 1'b0;
        #1;
        check("midreset_valid_out", {127'b0, valid_out}, 128'd0);
        check("midreset_ready_in", {127'b0, ready_in}, 128'd1);
        step();
        step();
        ready_out = 1'b1;
        reset     = 1'b1;
        count     = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (valid_out) count++;
        end
        check("stale_out", 128'(count), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
